des_core_unrolled: RTL
======================

Name: des_core_unrolled

Overview:
- Iterative DES encrypt/decrypt core with a compile-time unroll factor.
- UNROLL Feistel rounds are evaluated combinationally per clock; 16/UNROLL round cycles complete one 64-bit block.
- Successor to the fixed two-round-per-cycle encryptor. Adds a decrypt mode (reversed key order), a ready/start handshake with back-to-back acceptance, and a registered result.
- Round keys come from the external key-schedule block as a flat 768-bit bus.

Parameters:
UNROLL, 2, Feistel rounds per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
NR, 16/UNROLL (localparam), number of round cycles per block.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; accepted only on a clock edge where ready=1.
mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
message  input  64  [1:64] DES bit numbering; plaintext or ciphertext; sampled on accept.
round_keys  input  768  [1:768]; K1 in [1:48] through K16 in [721:768]; sampled on accept.
ready  output  1  core can accept start this cycle.
done  output  1  registered one-cycle pulse; result valid.
result  output  64  [1:64]; registered; holds the last block until the next done.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ready=1, done=0, result=0, round counter=0, data and key registers cleared.
  - Reset asserted mid-block aborts the block: no done pulse and result=0.
- States:
  - IDLE: ready=1. On start=1 -> ROUND. On the same edge, L||R <= IP(message), key register <= round_keys, dir <= mode, counter <= 0.
  - ROUND: ready=0. Each edge applies UNROLL rounds in sequence to L||R and increments counter. When counter==NR-1 -> DONE; on that same edge result <= IPinv(R16||L16) (final swap) and done <= 1.
  - DONE: ready=1, done=1 for exactly this cycle.
    - start=1 -> ROUND, loading a new block exactly as in IDLE (back-to-back; no dead cycle).
    - start=0 -> IDLE.
- Latency:
  - done is high in the cycle following edge E0+NR, where E0 is the accept edge.
  - Throughput is one block per NR+1 cycles.
  - UNROLL=1: 17 cycles; UNROLL=2: 9; UNROLL=16: 2.
- Key ordering:
  - Encrypt: the k-th round overall uses Kk.
  - Decrypt: the k-th round overall uses K(17-k).
  - Implementation: a key register shifted by 48*UNROLL per round cycle — left for encrypt, right for decrypt, with slices taken from the opposite end. Any equivalent indexing is acceptable.
  - Within one cycle, rounds are applied in ascending k.
- Handshake edge cases:
  - start while ready=0 is ignored. message, mode and round_keys are not resampled and the current block is undisturbed.
  - Input changes after the accept edge have no effect on the block in flight.
  - done never asserts without a prior accepted start. Exactly one done per accepted block.
- Arithmetic:
  - Counter width is $clog2(NR)+1 bits; no wrap within a block.
  - No round-to-round state exists outside the L, R and key registers.

Decomposition:
- Package des_pkg:
  - IP, IP-inverse, E, P and PC tables as constants.
  - The eight S-boxes as a constant array.
  - Widths: BLOCK_W=64, HALF_W=32, SUBKEY_W=48, NUM_ROUNDS=16.
  - State enum typedef {IDLE, ROUND, DONE}.
- Sub-module des_round_comb: purely combinational single Feistel round (L_in, R_in, Kn -> L_out, R_out). Instantiated UNROLL times in a generate chain.
- Existing ip_permutation and ip_inverse_permutation are reused unchanged.

Test Plan:
1. FIPS vector: key 133457799BBCDFF1 (bench expands to 768-bit round_keys), mode=0, message 0123456789ABCDEF -> result 85E813540F0AB405 with a single done pulse. Run for UNROLL=1, 2, 4, 8, 16; done appears 17, 9, 5, 3, 2 cycles after the accept edge respectively.
2. Decrypt: same keys, mode=1, message 85E813540F0AB405 -> result 0123456789ABCDEF with identical latency.
3. Back-to-back: start held high across blocks with messages 0123456789ABCDEF then 85E813540F0AB405 (alternating mode 0 then 1) -> accepts occur in consecutive DONE cycles. Outputs are 85E813540F0AB405 then 0123456789ABCDEF, with done pulses exactly NR+1 cycles apart.
4. Busy ignore: with UNROLL=1, pulse start with message FFFFFFFFFFFFFFFF at cycles 3 and 8 after the first accept -> ready=0 throughout, and the result matches the first message only.
5. Reset mid-block: assert rst asynchronously between edges at round cycle NR/2 -> ready=1, done=0 and result=0 immediately. After release a fresh block yields the correct result and no stale done.
6. Random regression: 1000 random key/message/mode triples checked against a software DES model. Property checks: done is one cycle wide, ready is never high in ROUND, result is stable between done pulses.

Source files
------------

// File: rtl/des_pkg.sv
// DES constants, widths and bit-numbered helper functions shared by the unrolled core.
// All vectors use [1:N] so indices match the DES tables directly.
package des_pkg;

  localparam int unsigned BLOCK_W    = 64;
  localparam int unsigned HALF_W     = 32;
  localparam int unsigned SUBKEY_W   = 48;
  localparam int unsigned NUM_ROUNDS = 16;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int IPI_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box is stored row-major: entry index = row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [1:BLOCK_W] ip_permutation(input logic [1:BLOCK_W] d);
    logic [1:BLOCK_W] o;
    for (int unsigned i = 0; i < BLOCK_W; i++) o[i+1] = d[IP_T[i]];
    return o;
  endfunction

  function automatic logic [1:BLOCK_W] ip_inverse_permutation(input logic [1:BLOCK_W] d);
    logic [1:BLOCK_W] o;
    for (int unsigned i = 0; i < BLOCK_W; i++) o[i+1] = d[IPI_T[i]];
    return o;
  endfunction

  function automatic logic [1:SUBKEY_W] e_expand(input logic [1:HALF_W] r);
    logic [1:SUBKEY_W] o;
    for (int unsigned i = 0; i < SUBKEY_W; i++) o[i+1] = r[E_T[i]];
    return o;
  endfunction

  // Outer bits (1 and 6) of each 6-bit group pick the row, inner four the column.
  function automatic logic [1:HALF_W] sbox_substitute(input logic [1:SUBKEY_W] x);
    logic [1:HALF_W] o;
    logic [5:0]      b;
    logic [3:0]      v;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 0; j < 6; j++) b[5-j] = x[6*i+1+j];
      v = 4'(SBOX[i][{b[5], b[0], b[4:1]}]);
      for (int unsigned j = 0; j < 4; j++) o[4*i+1+j] = v[3-j];
    end
    return o;
  endfunction

  function automatic logic [1:HALF_W] p_permute(input logic [1:HALF_W] d);
    logic [1:HALF_W] o;
    for (int unsigned i = 0; i < HALF_W; i++) o[i+1] = d[P_T[i]];
    return o;
  endfunction

endpackage

// File: rtl/des_core_unrolled_if.sv
// Request/result bundle between a DES core and its client.
interface des_core_unrolled_if;
  import des_pkg::*;

  logic                                start;
  logic                                mode;
  logic [1:BLOCK_W]                    message;
  logic [1:NUM_ROUNDS*SUBKEY_W]        round_keys;
  logic                                ready;
  logic                                done;
  logic [1:BLOCK_W]                    result;

  modport master (
    output start, mode, message, round_keys,
    input  ready, done, result
  );

  modport slave (
    input  start, mode, message, round_keys,
    output ready, done, result
  );
endinterface

// File: rtl/des_round_comb.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, Kn).
module des_round_comb
  import des_pkg::*;
(
  input  logic [1:HALF_W]   l_in,
  input  logic [1:HALF_W]   r_in,
  input  logic [1:SUBKEY_W] kn,
  output logic [1:HALF_W]   l_out,
  output logic [1:HALF_W]   r_out
);

  always_comb begin
    l_out = r_in;
    r_out = l_in ^ p_permute(sbox_substitute(e_expand(r_in) ^ kn));
  end

endmodule

// File: rtl/des_core_unrolled.sv
// Iterative DES encrypt/decrypt core: UNROLL rounds per clock, 16/UNROLL clocks per block,
// ready/start handshake with back-to-back acceptance from the DONE state.
module des_core_unrolled
  import des_pkg::*;
#(
  parameter int unsigned UNROLL = 2
) (
  input  logic           clk,
  input  logic           rst,
  des_core_unrolled_if.slave bus
);

  localparam int unsigned NR     = NUM_ROUNDS / UNROLL;
  localparam int unsigned CNT_W  = $clog2(NR) + 1;
  localparam int unsigned KEYS_W = NUM_ROUNDS * SUBKEY_W;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("des_core_unrolled: UNROLL must be 1, 2, 4, 8 or 16");
  end

  state_t              state_q;
  logic [1:HALF_W]     l_q, r_q;
  logic [1:KEYS_W]     key_q;
  logic                dir_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ready_q, done_q;
  logic [1:BLOCK_W]    result_q;

  logic [1:HALF_W]     l_ch [UNROLL+1];
  logic [1:HALF_W]     r_ch [UNROLL+1];
  logic [1:SUBKEY_W]   kn   [UNROLL];

  assign l_ch[0] = l_q;
  assign r_ch[0] = r_q;

  // Encrypt consumes keys from the [1] end and shifts left; decrypt from the [768] end and shifts right.
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    assign kn[j] = dir_q ? key_q[KEYS_W - SUBKEY_W*(j+1) + 1 +: SUBKEY_W]
                         : key_q[SUBKEY_W*j + 1 +: SUBKEY_W];

    des_round_comb u_round (
      .l_in  (l_ch[j]),
      .r_in  (r_ch[j]),
      .kn    (kn[j]),
      .l_out (l_ch[j+1]),
      .r_out (r_ch[j+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      l_q      <= '0;
      r_q      <= '0;
      key_q    <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            {l_q, r_q} <= ip_permutation(bus.message);
            key_q      <= bus.round_keys;
            dir_q      <= bus.mode;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            state_q    <= ROUND;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        ROUND: begin
          l_q   <= l_ch[UNROLL];
          r_q   <= r_ch[UNROLL];
          key_q <= dir_q ? (key_q >> (SUBKEY_W*UNROLL)) : (key_q << (SUBKEY_W*UNROLL));
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NR - 1)) begin
            result_q <= ip_inverse_permutation({r_ch[UNROLL], l_ch[UNROLL]});
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
